// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with opcode pre-decode into immediate format at enqueue.
// Latency: a word pushed in cycle N is visible at out_* in cycle N+1 (no empty bypass).
// Backpressure: in_ready drops when DEPTH entries are held; it depends on registered count only.
module if_id_queue #(
    parameter int         DEPTH    = 2,
    parameter int         XLEN     = 32,
    parameter logic [2:0] IMM_NONE = 3'b111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    // Immediate-format codes shared with the immediate extender in decode.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Entry storage; no reset needed since count gates visibility.
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [2:0]      imm_mem  [DEPTH];
    logic            ill_mem  [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic       push;
    logic       pop;
    logic [2:0] dec_imm;
    logic       dec_ill;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pre-decode the incoming opcode so decode never sits behind an opcode compare.
    always_comb begin
        dec_imm = IMM_NONE;
        dec_ill = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b1110011, 7'b0001111:             dec_imm = IMM_I;
            7'b0100011:                         dec_imm = IMM_S;
            7'b1100011:                         dec_imm = IMM_B;
            7'b0110111, 7'b0010111:             dec_imm = IMM_U;
            7'b1101111:                         dec_imm = IMM_J;
            7'b0110011:                         dec_imm = IMM_NONE;
            default: begin
                // Covers unknown opcodes and any inst[1:0] != 2'b11.
                dec_imm = IMM_NONE;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Pointer and occupancy update; reset beats flush, flush discards same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write the accepted word and its pre-decode into the tail slot.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            pc_mem[wptr]   <= in_pc;
            inst_mem[wptr] <= in_inst;
            imm_mem[wptr]  <= dec_imm;
            ill_mem[wptr]  <= dec_ill;
        end
    end

    // Present the head entry, masked to idle values when the queue is empty.
    always_comb begin
        out_pc       = '0;
        out_inst     = '0;
        out_imm_type = IMM_NONE;
        out_illegal  = 1'b0;
        if (out_valid) begin
            out_pc       = pc_mem[rptr];
            out_inst     = inst_mem[rptr];
            out_imm_type = imm_mem[rptr];
            out_illegal  = ill_mem[rptr];
        end
    end

endmodule
